ln_range_reduce_seq: RTL and testbench
======================================

# ln_range_reduce_seq

Sequential range-reduction controller for the natural-log path. It accepts one IEEE-754 single-precision operand over a valid/ready handshake and halves it repeatedly, one step per clock, until the value is below 2.0 or the iteration cap is reached. It then returns the halving count `n` (as a float) and the reduced mantissa-range value `x` to the downstream ln series unit. It replaces the 30-stage unrolled divide/sum chain with a single reused halving step, trading latency for area.

## Interface
- `MAX_ITER`, default 30: maximum number of halvings; range 1..255.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand valid.
- `in_ready` output 1: high only in IDLE with `rst` low.
- `in_a` input 32: IEEE-754 single operand.
- `out_valid` output 1: result valid; held until accepted.
- `out_ready` input 1: downstream accepts the result.
- `out_n` output 32: halving count as an IEEE-754 single.
- `out_x` output 32: reduced value, IEEE-754 single.
- `busy` output 1: high in REDUCE or DONE.

## Operation
- FSM states: IDLE, REDUCE, DONE.
- **IDLE**
  - On `in_valid && in_ready`: register `x = in_a` and integer `cnt = 0`, then go to REDUCE.
- **REDUCE**, evaluated each cycle:
  - `x < 2.0` is true if `x[31]` is 1 (any negative, including -0), or if `x[30:0] < 31'h40000000`.
  - If `x < 2.0` or `cnt == MAX_ITER`: go to DONE.
  - Otherwise: halve `x` and set `cnt++`.
- **Halving step**
  - Decrement the exponent field `x[30:23]`. It is always ≥128 here, so there is no underflow.
  - If the exponent is 255 (Inf/NaN), `x` is unchanged and `cnt` still increments. Inf/NaN therefore terminates by the cap.
- **DONE**
  - `out_valid = 1`.
  - `out_x = x`, except `x == 32'h3F800000` is emitted as `32'h3F800001`. This keeps the ln unit off its singular point.
  - `out_n` is `cnt` converted exactly to a float:
    - 0 maps to `32'h00000000`.
    - Otherwise sign 0, exponent `127+msb(cnt)`, mantissa `cnt` left-justified with its leading 1 dropped.
  - On `out_ready`: go to IDLE.
- `cnt` width is `$clog2(MAX_ITER+1)` bits; it never exceeds `MAX_ITER`.
- Reset values: state IDLE, `out_valid=0`, `out_n=0`, `out_x=0`, `busy=0`, `in_ready=0` while `rst` is high. `in_ready` is 1 in the first cycle after `rst` deasserts.

## Timing
- Input accepted on edge E0.
- For k halvings, REDUCE occupies k+1 cycles.
- `out_valid` rises after edge E0+k+1, giving latency k+1 cycles (min 1, max `MAX_ITER+1`).
- `out_n` and `out_x` are registered and stable for the whole time `out_valid` is high. They change only on the edge that enters DONE.
- Result accepted on the edge where `out_valid && out_ready`. IDLE is re-entered on that edge, and the next input can be accepted one cycle later (no back-to-back overlap).
- While `in_ready=0`, `in_valid` is ignored and the operand is not captured.
- `rst` during REDUCE or DONE abandons the operation. On the next edge, `out_valid=0`, `busy=0`, and the pending result is lost.
- `rst` has priority over a simultaneous handshake.

## Configuration
- `LN_REDUCE_ONESHOT_EN` defined: REDUCE always takes exactly one cycle, so latency is constant at 1.
  - `k` is computed directly as `min(max(e-127,0), MAX_ITER)`, where `e` is the exponent of a positive `x ≥ 2.0`.
  - `k = 0` for `x < 2.0`; `k = MAX_ITER` for exponent 255.
  - `x` exponent is reduced by `k`; Inf/NaN is unchanged.
  - `out_n`, `out_x` and the 1.0 nudge are bit-identical to the iterative mode.
- Undefined: iterative one-halving-per-cycle behaviour as described above.

## Test plan
- `in_a=32'h41400000` (12.0) → `out_n=32'h40400000` (3.0), `out_x=32'h3FC00000` (1.5), `out_valid` 4 cycles after accept (1 cycle with ONESHOT).
- `in_a=32'h41000000` (8.0) → `out_n=32'h40400000`, `out_x=32'h3F800001` (nudged 1.0); `in_a=32'h3F800000` → `out_n=0`, `out_x=32'h3F800001`.
- `in_a=32'hC0A00000` (-5.0) and `32'h3FC00000` (1.5) → `out_n=0`, `out_x` equal to input, latency 1.
- `in_a=32'h53800000` (2^40) → cap hit: `out_n=32'h41F00000` (30.0), `out_x=32'h44800000` (1024.0), latency 31. `in_a=32'h7F800000` → `out_n=32'h41F00000`, `out_x=32'h7F800000`.
- Hold `out_ready=0` for 5 cycles in DONE → `out_n`/`out_x` stable, `in_ready=0`, and a new `in_valid` is not captured. Assert `out_ready` → IDLE next edge, `in_ready=1`.
- Assert `rst` for 1 cycle mid-REDUCE on 12.0 → `out_valid` never asserts for it, `busy=0` and `out_*=0` after the edge, and a fresh 12.0 then completes normally.

Source files
------------

// File: rtl/ln_range_reduce_seq_if.sv
// Handshake bundle for ln_range_reduce_seq: operand in, (n, x) result out.
// The master side drives operands and accepts results; the slave side is the reducer.
interface ln_range_reduce_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_n;
  logic [31:0] out_x;

  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_n, out_x
  );

  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_n, out_x
  );
endinterface

// File: rtl/ln_range_reduce_seq.sv
// Range reduction for the ln path: halves a single-precision operand until it drops below 2.0.
// Define LN_REDUCE_ONESHOT_EN to compute the halving count in one cycle instead of iterating.
module ln_range_reduce_seq #(
  parameter int MAX_ITER = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  ln_range_reduce_seq_if.slave bus,
  output logic                 busy
);

  localparam int CW = $clog2(MAX_ITER + 1);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] x;
  logic [31:0] res_x;
  logic [7:0]  res_k;
  logic        finish;
  logic        lt2;
  logic [7:0]  exp_f;
  logic [31:0] out_n_q;
  logic [31:0] out_x_q;

  // Exact int-to-float for counts up to 255; the leading one falls off the top of the mantissa.
  function automatic logic [31:0] count_to_float(input logic [7:0] c);
    logic [31:0] f;
    logic [22:0] m;
    int          msb;
    f   = '0;
    msb = 0;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) msb = i;
    end
    m = 23'(c) << (23 - msb);
    if (c != 8'd0) f = {1'b0, 8'(127 + msb), m};
    return f;
  endfunction

  // Exactly 1.0 is the ln unit's singular point, so step one ulp above it.
  function automatic logic [31:0] nudge(input logic [31:0] v);
    return (v == 32'h3F800000) ? 32'h3F800001 : v;
  endfunction

  assign exp_f = x[30:23];
  assign lt2   = x[31] || (x[30:0] < 31'h40000000);

`ifdef LN_REDUCE_ONESHOT_EN
  always_comb begin
    res_k  = '0;
    res_x  = x;
    finish = 1'b1;
    if (!lt2) begin
      if (exp_f == 8'hFF) begin
        res_k = 8'(MAX_ITER);
      end else if ((int'(exp_f) - 127) > MAX_ITER) begin
        res_k = 8'(MAX_ITER);
      end else begin
        res_k = exp_f - 8'd127;
      end
      if (exp_f != 8'hFF) res_x[30:23] = exp_f - res_k;
    end
  end
`else
  logic [CW-1:0] cnt;

  always_comb begin
    finish = lt2 || (cnt == CW'(MAX_ITER));
    res_k  = 8'(cnt);
    res_x  = x;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = REDUCE;
      REDUCE:  if (finish)        state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      out_n_q <= '0;
      out_x_q <= '0;
`ifndef LN_REDUCE_ONESHOT_EN
      cnt     <= '0;
`endif
    end else if (state == IDLE && bus.in_valid) begin
      x <= bus.in_a;
`ifndef LN_REDUCE_ONESHOT_EN
      cnt <= '0;
`endif
    end else if (state == REDUCE) begin
      if (finish) begin
        out_x_q <= nudge(res_x);
        out_n_q <= count_to_float(res_k);
      end else begin
`ifdef LN_REDUCE_ONESHOT_EN
        x <= x;
`else
        // Inf/NaN keep their exponent and only run down the iteration cap.
        if (exp_f != 8'hFF) x[30:23] <= exp_f - 8'd1;
        cnt <= cnt + CW'(1);
`endif
      end
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_n     = out_n_q;
  assign bus.out_x     = out_x_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ln_range_reduce_seq.sv
// Self-checking bench for ln_range_reduce_seq: directed vector table, handshake/reset
// corner sequences, and random operands against an exponent-arithmetic reference model.
module tb_ln_range_reduce_seq;

  localparam int MAX_ITER = 30;
`ifdef LN_REDUCE_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] n;
    logic [31:0] x;
    int          lat;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   passes = 0;

  ln_range_reduce_seq_if bus();

  ln_range_reduce_seq #(.MAX_ITER(MAX_ITER)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Halvings needed = binary exponent of a positive x >= 2, capped; count built via a double.
  task automatic ref_model(input logic [31:0] a, output logic [31:0] n,
                           output logic [31:0] x, output int lat);
    int          e;
    int          k;
    real         r;
    logic [63:0] d;
    e = int'(a[30:23]);
    x = a;
    if (a[31] || e < 128) begin
      k = 0;
    end else if (e == 255) begin
      k = MAX_ITER;
    end else begin
      k = e - 127;
      if (k > MAX_ITER) k = MAX_ITER;
      x[30:23] = 8'(e - k);
    end
    if (x == 32'h3F800000) x = 32'h3F800001;
    r = k;
    d = $realtobits(r);
    n = (k == 0) ? 32'h0 : {1'b0, 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    lat = ONESHOT ? 1 : k + 1;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checks++;
      $display("[TB] FAIL in_ready_wait: got in_ready=0, expected 1 within 40 cycles");
      ok = 1'b0;
      return;
    end
    bus.in_a     = a;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < MAX_ITER + 5) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_and_check(input logic [31:0] a, input logic [31:0] en,
                               input logic [31:0] ex, input int el, input string name);
    bit ok;
    int lat;
    apply_stimulus(a, ok);
    if (!ok) return;
    wait_result(lat);
    check_output({name, "_latency"}, 32'(lat), 32'(el));
    check_output({name, "_out_n"}, bus.out_n, en);
    check_output({name, "_out_x"}, bus.out_x, ex);
    accept_result();
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] rn;
    logic [31:0] rx;
    logic [31:0] ra;
    int          rl;
    int          seen;
    int          cat;
    bit          ok;

    vecs[0] = '{32'h41400000, 32'h40400000, 32'h3FC00000, ONESHOT ? 1 : 4,  "v12_0"};
    vecs[1] = '{32'h41000000, 32'h40400000, 32'h3F800001, ONESHOT ? 1 : 4,  "v8_0"};
    vecs[2] = '{32'h3F800000, 32'h00000000, 32'h3F800001, 1,                "v1_0"};
    vecs[3] = '{32'hC0A00000, 32'h00000000, 32'hC0A00000, 1,                "vneg5"};
    vecs[4] = '{32'h3FC00000, 32'h00000000, 32'h3FC00000, 1,                "v1_5"};
    vecs[5] = '{32'h53800000, 32'h41F00000, 32'h44800000, ONESHOT ? 1 : 31, "vcap"};
    vecs[6] = '{32'h7F800000, 32'h41F00000, 32'h7F800000, ONESHOT ? 1 : 31, "vinf"};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_busy",      32'(busy),          32'h0);
    check_output("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("reset_in_ready",  32'(bus.in_ready),  32'h0);
    check_output("reset_out_n",     bus.out_n,          32'h0);
    check_output("reset_out_x",     bus.out_x,          32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_output("post_reset_in_ready", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < 7; i++)
      run_and_check(vecs[i].a, vecs[i].n, vecs[i].x, vecs[i].lat, vecs[i].name);

    // Result held in DONE while downstream stalls; a new operand must be ignored.
    apply_stimulus(32'h41400000, ok);
    wait_result(rl);
    check_output("hold_out_valid", 32'(bus.out_valid), 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h40000000;
      @(posedge clk);
      #1;
      check_output("hold_out_n",    bus.out_n,          32'h40400000);
      check_output("hold_out_x",    bus.out_x,          32'h3FC00000);
      check_output("hold_in_ready", 32'(bus.in_ready),  32'h0);
      check_output("hold_valid",    32'(bus.out_valid), 32'h1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check_output("release_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("release_in_ready",  32'(bus.in_ready),  32'h1);
    check_output("release_busy",      32'(busy),          32'h0);

    // Reset mid-operation discards the pending result.
    apply_stimulus(32'h41400000, ok);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_busy",      32'(busy),          32'h0);
    check_output("abort_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("abort_out_n",     bus.out_n,          32'h0);
    check_output("abort_out_x",     bus.out_x,          32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen++;
    end
    check_output("abort_no_result", 32'(seen), 32'h0);
    run_and_check(32'h41400000, 32'h40400000, 32'h3FC00000, ONESHOT ? 1 : 4, "after_abort");

    for (int i = 0; i < 40; i++) begin
      cat = $urandom_range(0, 4);
      case (cat)
        0:       ra = {1'b0, 8'($urandom_range(100, 200)), 23'($urandom)};
        1:       ra = {1'b1, 31'($urandom)};
        2:       ra = {1'b0, 8'hFF, 23'($urandom)};
        3:       ra = {1'b0, 8'($urandom_range(126, 129)), ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom)};
        default: ra = $urandom;
      endcase
      ref_model(ra, rn, rx, rl);
      run_and_check(ra, rn, rx, rl, "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
